lc3b_control: RTL

- Multi-cycle Moore control FSM for the LC-3b core.
- Sits directly upstream of the datapath. Consumes opcode and branch_enable from the datapath and the memory response handshake.
- Drives every datapath load enable, mux select and ALU op, plus the memory read/write strobes.
- Supports ADD, AND, NOT, BR, LDR and STR. Any other opcode is treated as a no-op and fetch restarts.

---
 rtl/lc3b_types.sv | 21 ++
 rtl/lc3b_control.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b encodings for opcodes and ALU operations.
// Imported by the control FSM and the datapath.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br  = 4'b0000,
    op_add = 4'b0001,
    op_and = 4'b0101,
    op_ldr = 4'b0110,
    op_str = 4'b0111,
    op_not = 4'b1001
  } lc3b_opcode;

  typedef enum logic [1:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass
  } lc3b_aluop;

endpackage

// File: rtl/lc3b_control.sv
// LC-3b multi-cycle Moore control FSM.
// Drives datapath enables, mux selects, ALU op and memory strobes.
module lc3b_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [1:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  typedef enum logic [3:0] {
    s_fetch1,
    s_fetch2,
    s_fetch3,
    s_decode,
    s_add,
    s_and,
    s_not,
    s_br,
    s_br_taken,
    s_calc_addr,
    s_ldr1,
    s_ldr2,
    s_str1,
    s_str2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  lc3b_opcode w_op;

  assign w_op = lc3b_opcode'(opcode);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= s_fetch1;
    else          r_state <= w_next;
  end

  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_cc         = 1'b0;
    pcmux_sel       = 1'b0;
    storemux_sel    = 1'b0;
    alumux_sel      = 1'b0;
    regfilemux_sel  = 1'b0;
    marmux_sel      = 1'b0;
    mdrmux_sel      = 1'b0;
    aluop           = alu_add;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b11;
    unique case (r_state)
      s_fetch1: begin
        marmux_sel = 1'b1;
        load_mar   = 1'b1;
        load_pc    = 1'b1;
      end
      s_fetch2, s_ldr1: begin
        mem_read   = 1'b1;
        mdrmux_sel = 1'b1;
        load_mdr   = 1'b1;
      end
      s_fetch3: load_ir = 1'b1;
      s_add, s_and, s_not: begin
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        if (r_state == s_and)      aluop = alu_and;
        else if (r_state == s_not) aluop = alu_not;
      end
      s_br_taken: begin
        pcmux_sel = 1'b1;
        load_pc   = 1'b1;
      end
      s_calc_addr: begin
        alumux_sel = 1'b1;
        load_mar   = 1'b1;
      end
      s_ldr2: begin
        regfilemux_sel = 1'b1;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
      end
      s_str1: begin
        storemux_sel = 1'b1;
        aluop        = alu_pass;
        load_mdr     = 1'b1;
      end
      s_str2: mem_write = 1'b1;
      default: ;
    endcase
    // Reset must silence every side effect, even mid-transaction.
    if (!reset_n) begin
      load_pc      = 1'b0;
      load_ir      = 1'b0;
      load_regfile = 1'b0;
      load_mar     = 1'b0;
      load_mdr     = 1'b0;
      load_cc      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
    end
  end

  always_comb begin
    w_next = s_fetch1;
    unique case (r_state)
      s_fetch1: w_next = s_fetch2;
      s_fetch2: w_next = mem_resp ? s_fetch3 : s_fetch2;
      s_fetch3: w_next = s_decode;
      s_decode: begin
        case (w_op)
          op_add:  w_next = s_add;
          op_and:  w_next = s_and;
          op_not:  w_next = s_not;
          op_br:   w_next = s_br;
          op_ldr:  w_next = s_calc_addr;
          op_str:  w_next = s_calc_addr;
          default: w_next = s_fetch1;
        endcase
      end
      s_br:        w_next = branch_enable ? s_br_taken : s_fetch1;
      s_calc_addr: w_next = (w_op == op_str) ? s_str1 : s_ldr1;
      s_ldr1:      w_next = mem_resp ? s_ldr2 : s_ldr1;
      s_str1:      w_next = s_str2;
      s_str2:      w_next = mem_resp ? s_fetch1 : s_str2;
      default:     w_next = s_fetch1;
    endcase
  end

endmodule
